alu_sequencer: RTL and testbench

Multicycle issue controller that drives the 9-bit ALU from the instruction side. It accepts instruction words over a valid/ready handshake and holds a 4-entry × 9-bit register file. It presents operands and a 4-bit opcode to the ALU, captures the ALU's combinational result one cycle later and writes it back. It is the control-plane counterpart of the ALU and replaces the ALU's simulation-only halt with a real HALT state.

---
 rtl/alu_pkg.sv | 37 +++
 rtl/alu_sequencer_if.sv | 28 ++
 rtl/alu_sequencer_regfile.sv | 32 +++
 rtl/alu_sequencer.sv | 116 +++++++++++
 tb/tb_alu_sequencer.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types and instruction-word layout for the ALU issue sequencer.
package alu_pkg;

  localparam int unsigned W      = 9;
  localparam int unsigned NREGS  = 4;
  localparam int unsigned InstrW = 18;

  localparam int unsigned OpMsb     = 17;
  localparam int unsigned OpLsb     = 14;
  localparam int unsigned RdMsb     = 13;
  localparam int unsigned RdLsb     = 12;
  localparam int unsigned RaMsb     = 11;
  localparam int unsigned RaLsb     = 10;
  localparam int unsigned UseImmBit = 9;
  localparam int unsigned BMsb      = 8;
  localparam int unsigned BLsb      = 0;

  // 4'b1100..4'b1110 are unnamed: issued normally, the ALU returns 0
  typedef enum logic [3:0] {
    OpAnd   = 4'b0000,
    OpOr    = 4'b0001,
    OpNot   = 4'b0010,
    OpAdd   = 4'b0011,
    OpPassa = 4'b0100,
    OpShl   = 4'b0101,
    OpShr   = 4'b0110,
    OpSub   = 4'b0111,
    OpAdd2  = 4'b1000,
    OpSub2  = 4'b1001,
    OpPassb = 4'b1010,
    OpNop   = 4'b1011,
    OpHalt  = 4'b1111
  } opcode_e;

  typedef enum logic [1:0] {StIdle, StIssue, StWrite, StHalt} state_e;

endpackage

// File: rtl/alu_sequencer_if.sv
// Instruction handshake, ALU operand/result and writeback signals of the sequencer.
interface alu_sequencer_if
  import alu_pkg::*;
#(
  parameter int unsigned DW = alu_pkg::W
);
  logic              instr_valid;
  logic [InstrW-1:0] instr;
  logic              instr_ready;
  logic [DW-1:0]     alu_a;
  logic [DW-1:0]     alu_b;
  logic [3:0]        alu_op;
  logic [DW-1:0]     alu_out;
  logic              result_valid;
  logic [DW-1:0]     result_data;
  logic [1:0]        result_rd;
  logic              halted;

  modport slave (
    input  instr_valid, instr, alu_out,
    output instr_ready, alu_a, alu_b, alu_op, result_valid, result_data, result_rd, halted
  );

  modport master (
    output instr_valid, instr, alu_out,
    input  instr_ready, alu_a, alu_b, alu_op, result_valid, result_data, result_rd, halted
  );
endinterface

// File: rtl/alu_sequencer_regfile.sv
// Register file: two combinational read ports, one synchronous write port, cleared on reset.
module alu_sequencer_regfile #(
  parameter int unsigned NREGS = 4,
  parameter int unsigned W     = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   ra_idx,
  input  logic [1:0]   rb_idx,
  output logic [W-1:0] ra_data,
  output logic [W-1:0] rb_data,
  input  logic         we,
  input  logic [1:0]   wa,
  input  logic [W-1:0] wd
);

  logic [W-1:0] mem_q [NREGS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[wa] <= wd;
    end
  end

  assign ra_data = mem_q[ra_idx];
  assign rb_data = mem_q[rb_idx];

endmodule

// File: rtl/alu_sequencer.sv
// Multicycle issue controller: accept, issue operands to the external ALU, write back.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned NREGS = 4,
  parameter int unsigned W     = alu_pkg::W
) (
  input logic            clk,
  input logic            reset,
  alu_sequencer_if.slave bus
);

  state_e            state_q;
  logic [InstrW-1:0] ir_q;
  logic              ready_q;
  logic [W-1:0]      alu_a_q;
  logic [W-1:0]      alu_b_q;
  logic [3:0]        alu_op_q;
  logic              rv_q;
  logic [W-1:0]      rdata_q;
  logic [1:0]        rrd_q;
  logic              halted_q;

  logic [3:0]   op;
  logic [1:0]   rd;
  logic [1:0]   ra;
  logic         use_imm;
  logic [W-1:0] bfield;
  logic [W-1:0] ra_data;
  logic [W-1:0] rb_data;
  logic         we;

  assign op      = ir_q[OpMsb:OpLsb];
  assign rd      = ir_q[RdMsb:RdLsb];
  assign ra      = ir_q[RaMsb:RaLsb];
  assign use_imm = ir_q[UseImmBit];
  assign bfield  = ir_q[BMsb:BLsb];

  // Commit happens at the end of WRITE, so the next ISSUE already sees it
  assign we = (state_q == StWrite) && (op != OpNop);

  alu_sequencer_regfile #(
    .NREGS (NREGS),
    .W     (W)
  ) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .ra_idx  (ra),
    .rb_idx  (bfield[1:0]),
    .ra_data (ra_data),
    .rb_data (rb_data),
    .we      (we),
    .wa      (rd),
    .wd      (bus.alu_out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      ir_q     <= '0;
      ready_q  <= 1'b1;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= OpNop;
      rv_q     <= 1'b0;
      rdata_q  <= '0;
      rrd_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      rv_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.instr_valid && ready_q) begin
            ir_q    <= bus.instr;
            ready_q <= 1'b0;
            if (bus.instr[OpMsb:OpLsb] == OpHalt) begin
              state_q  <= StHalt;
              halted_q <= 1'b1;
            end else begin
              state_q <= StIssue;
            end
          end
        end
        StIssue: begin
          alu_a_q  <= ra_data;
          alu_b_q  <= use_imm ? bfield : rb_data;
          alu_op_q <= op;
          state_q  <= StWrite;
        end
        StWrite: begin
          if (op != OpNop) begin
            rv_q    <= 1'b1;
            rdata_q <= bus.alu_out;
            rrd_q   <= rd;
          end
          ready_q <= 1'b1;
          state_q <= StIdle;
        end
        StHalt: begin
          state_q <= StHalt;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.instr_ready  = ready_q;
  assign bus.alu_a        = alu_a_q;
  assign bus.alu_b        = alu_b_q;
  assign bus.alu_op       = alu_op_q;
  assign bus.result_valid = rv_q;
  assign bus.result_data  = rdata_q;
  assign bus.result_rd    = rrd_q;
  assign bus.halted       = halted_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural ALU plus a register-array reference model.
module tb_alu_sequencer;
  import alu_pkg::*;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_bad;
  logic [8:0] regs [4];

  alu_sequencer_if bus ();

  alu_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] alu_f(input logic [3:0] op, input logic [8:0] a,
                                       input logic [8:0] b);
    case (op)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return ~a;
      4'd3:    return a + b;
      4'd4:    return a;
      4'd5:    return a << 1;
      4'd6:    return a >> 1;
      4'd7:    return a - b;
      4'd8:    return a + b + 9'd1;
      4'd9:    return a - b - 9'd1;
      4'd10:   return b;
      default: return 9'd0;
    endcase
  endfunction

  assign bus.alu_out = alu_f(bus.alu_op, bus.alu_a, bus.alu_b);

  function automatic logic [17:0] mk(input logic [3:0] op, input logic [1:0] rd,
                                     input logic [1:0] ra, input logic imm,
                                     input logic [8:0] b);
    return {op, rd, ra, imm, b};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 4; i++) regs[i] = 9'd0;
  endtask

  // Issue one instruction and check the accept/issue/writeback timeline against the model
  task automatic send(input logic [17:0] w);
    logic [3:0] op;
    logic [1:0] rd, ra;
    logic [8:0] bf, a_exp, b_exp, r_exp;
    int n;
    op = w[17:14];
    rd = w[13:12];
    ra = w[11:10];
    bf = w[8:0];
    a_exp = regs[ra];
    b_exp = w[9] ? bf : regs[bf[1:0]];
    r_exp = alu_f(op, a_exp, b_exp);
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr = w;
    n = 0;
    while (!bus.instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.instr_ready) begin
      check("accept_timeout", 0, 1);
      bus.instr_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    check("ready_low", bus.instr_ready, 0);
    if (op == OpHalt) begin
      check("halted_set", bus.halted, 1);
      return;
    end
    check("rv_early0", bus.result_valid, 0);
    @(negedge clk);
    check("alu_op", bus.alu_op, op);
    check("alu_a", bus.alu_a, a_exp);
    check("alu_b", bus.alu_b, b_exp);
    check("rv_early1", bus.result_valid, 0);
    check("ready_low2", bus.instr_ready, 0);
    @(negedge clk);
    if (op == OpNop) begin
      check("nop_rv", bus.result_valid, 0);
    end else begin
      check("wb_rv", bus.result_valid, 1);
      check("wb_data", bus.result_data, r_exp);
      check("wb_rd", bus.result_rd, rd);
      regs[rd] = r_exp;
    end
    check("ready_back", bus.instr_ready, 1);
  endtask

  task automatic read_reg(input logic [1:0] r, input logic [8:0] want, input string tag);
    send(mk(OpPassa, r, r, 1'b0, 9'd0));
    check(tag, bus.result_data, want);
  endtask

  initial begin
    int rdy, pulses, acc;
    n_checks = 0;
    n_bad = 0;
    clear_model();
    reset = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", bus.instr_ready, 1);
    check("rst_alu_a", bus.alu_a, 0);
    check("rst_alu_b", bus.alu_b, 0);
    check("rst_alu_op", bus.alu_op, 4'b1011);
    check("rst_rv", bus.result_valid, 0);
    check("rst_rdata", bus.result_data, 0);
    check("rst_rrd", bus.result_rd, 0);
    check("rst_halted", bus.halted, 0);
    reset = 1'b0;

    // Load immediate, then copy
    send(mk(OpPassb, 2'd1, 2'd0, 1'b1, 9'h0A5));
    check("ld_r1", bus.result_data, 9'h0A5);
    send(mk(OpPassa, 2'd2, 2'd1, 1'b0, 9'd0));
    check("cp_r2", bus.result_data, 9'h0A5);

    // Add/sub wrap
    send(mk(OpPassb, 2'd0, 2'd0, 1'b1, 9'h1FF));
    send(mk(OpPassb, 2'd1, 2'd0, 1'b1, 9'h001));
    send(mk(OpAdd, 2'd2, 2'd0, 1'b0, 9'd1));
    check("add_wrap", bus.result_data, 9'h000);
    send(mk(OpSub, 2'd3, 2'd2, 1'b0, 9'd1));
    check("sub_wrap", bus.result_data, 9'h1FF);

    // Shifts
    send(mk(OpPassb, 2'd0, 2'd0, 1'b1, 9'h181));
    send(mk(OpShl, 2'd1, 2'd0, 1'b0, 9'd0));
    check("shl", bus.result_data, 9'h102);
    send(mk(OpShr, 2'd2, 2'd0, 1'b0, 9'd0));
    check("shr", bus.result_data, 9'h0C0);

    // Back-to-back dependent increments with valid held high
    send(mk(OpPassb, 2'd0, 2'd0, 1'b1, 9'd0));
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr = mk(OpAdd, 2'd0, 2'd0, 1'b1, 9'd1);
    rdy = 0;
    pulses = 0;
    acc = 0;
    for (int c = 0; c < 9; c++) begin
      if (bus.instr_ready) begin
        rdy++;
        acc++;
      end
      @(posedge clk);
      @(negedge clk);
      if (acc == 3) bus.instr_valid = 1'b0;
      if (bus.result_valid) pulses++;
    end
    bus.instr_valid = 1'b0;
    check("b2b_ready_cnt", rdy, 3);
    check("b2b_pulses", pulses, 3);
    check("b2b_last", bus.result_data, 9'd3);
    regs[0] = 9'd3;
    read_reg(2'd0, 9'd3, "b2b_r0");

    // Random instructions (HALT excluded)
    for (int i = 0; i < 40; i++) begin
      send(mk(4'($urandom_range(0, 14)), 2'($urandom), 2'($urandom), 1'($urandom),
              9'($urandom)));
    end
    for (int r = 0; r < 4; r++) read_reg(2'(r), regs[r], "rand_reg");

    // NOP leaves registers alone
    send(mk(OpNop, 2'd1, 2'd0, 1'b1, 9'h155));
    for (int r = 0; r < 4; r++) read_reg(2'(r), regs[r], "nop_reg");

    // Reset during the WRITE cycle of an ADD discards the writeback
    send(mk(OpPassb, 2'd0, 2'd0, 1'b1, 9'h055));
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr = mk(OpAdd, 2'd2, 2'd0, 1'b1, 9'd0);
    @(posedge clk);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_aluop", bus.alu_op, OpAdd);
    reset = 1'b1;
    #1;
    check("mid_rst_rv", bus.result_valid, 0);
    check("mid_rst_aluop", bus.alu_op, 4'b1011);
    check("mid_rst_alu_a", bus.alu_a, 0);
    check("mid_rst_ready", bus.instr_ready, 1);
    @(posedge clk);
    #1;
    check("mid_rst_rv2", bus.result_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    clear_model();
    read_reg(2'd2, 9'd0, "mid_rst_r2");
    read_reg(2'd0, 9'd0, "mid_rst_r0");

    // HALT is absorbing until reset
    send(mk(OpPassb, 2'd1, 2'd0, 1'b1, 9'h0AA));
    send(mk(OpHalt, 2'd0, 2'd0, 1'b0, 9'd0));
    bus.instr_valid = 1'b1;
    bus.instr = mk(OpPassb, 2'd1, 2'd0, 1'b1, 9'h1AA);
    rdy = 0;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.instr_ready) rdy++;
      if (bus.result_valid) pulses++;
    end
    bus.instr_valid = 1'b0;
    check("halt_ready", rdy, 0);
    check("halt_rv", pulses, 0);
    check("halt_stays", bus.halted, 1);
    reset = 1'b1;
    #1;
    check("unhalt", bus.halted, 0);
    check("unhalt_ready", bus.instr_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    clear_model();
    read_reg(2'd1, 9'd0, "post_halt_r1");

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
